// File: rtl/csr_file.sv
// Machine-mode CSR file: decode, CSRRW/RS/RC read-modify-write, illegal-access detection,
// 64-bit cycle/instret counters, trap-entry/MRET updates, trap vector and interrupt pending.
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1,
  parameter int          COUNTER_W   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instr_retire,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        sw_irq,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  output logic        irq_pending
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam int HI_W = COUNTER_W - 32;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  logic                 mstat_mie, mstat_mpie;
  logic [2:0]           mie_q;        // {MEIE, MTIE, MSIE}
  logic [29:0]          mtvec_base;
  logic                 mtvec_mode;
  logic [31:0]          mscratch;
  logic [29:0]          mepc_q;
  logic [31:0]          mcause;
  logic [31:0]          mtval;
  logic [COUNTER_W-1:0] mcycle_q, minstret_q;
  logic [COUNTER_W-1:0] mcycle_nxt, minstret_nxt;

  logic [31:0] mstatus_val, mie_val, mip_val;
  logic [63:0] cyc64, ins64;
  logic [31:0] old_val, wval;
  logic        impl, access, wr_req, illegal, we;
  logic [2:0]  irq_lines;

  assign irq_lines = {ext_irq, timer_irq, sw_irq};
  assign cyc64     = 64'(mcycle_q);
  assign ins64     = 64'(minstret_q);

  always_comb begin
    mstatus_val       = '0;
    mstatus_val[3]    = mstat_mie;
    mstatus_val[7]    = mstat_mpie;
    mstatus_val[12:11] = 2'b11;
    mie_val           = '0;
    mie_val[11]       = mie_q[2];
    mie_val[7]        = mie_q[1];
    mie_val[3]        = mie_q[0];
    mip_val           = '0;
    mip_val[11]       = ext_irq;
    mip_val[7]        = timer_irq;
    mip_val[3]        = sw_irq;
  end

  always_comb begin
    impl    = 1'b1;
    old_val = '0;
    case (csr_addr)
      A_MSTATUS:                old_val = mstatus_val;
      A_MISA:                   old_val = MISA_VAL;
      A_MIE:                    old_val = mie_val;
      A_MTVEC:                  old_val = {mtvec_base, 1'b0, mtvec_mode};
      A_MSCRATCH:               old_val = mscratch;
      A_MEPC:                   old_val = {mepc_q, 2'b00};
      A_MCAUSE:                 old_val = mcause;
      A_MTVAL:                  old_val = mtval;
      A_MIP:                    old_val = mip_val;
      A_MCYCLE,   A_CYCLE:      old_val = cyc64[31:0];
      A_MCYCLEH,  A_CYCLEH:     old_val = cyc64[63:32];
      A_MINSTRET, A_INSTRET:    old_val = ins64[31:0];
      A_MINSTRETH, A_INSTRETH:  old_val = ins64[63:32];
      A_MVENDORID, A_MARCHID, A_MIMPID: old_val = '0;
      A_MHARTID:                old_val = HART_ID;
      default:                  impl    = 1'b0;
    endcase
  end

  // RS/RC with a zero mask are pure reads and never count as writes.
  always_comb begin
    access  = csr_en && (csr_op_e'(csr_op) != OP_NONE);
    wr_req  = access && ((csr_op_e'(csr_op) == OP_RW) || (csr_wdata != 32'h0));
    illegal = access && (!impl || (wr_req && (csr_addr[11:10] == 2'b11)));
    we      = wr_req && !illegal;
    case (csr_op_e'(csr_op))
      OP_RS:   wval = old_val | csr_wdata;
      OP_RC:   wval = old_val & ~csr_wdata;
      default: wval = csr_wdata;
    endcase
  end

  assign csr_rdata   = (access && !illegal) ? old_val : 32'h0;
  assign csr_illegal = illegal;

  // A write to one counter half replaces that cycle's increment; the other half holds.
  always_comb begin
    mcycle_nxt   = mcycle_q + COUNTER_W'(1);
    minstret_nxt = instr_retire ? (minstret_q + COUNTER_W'(1)) : minstret_q;
    if (we) begin
      case (csr_addr)
        A_MCYCLE:    mcycle_nxt   = {mcycle_q[COUNTER_W-1:32], wval};
        A_MCYCLEH:   mcycle_nxt   = {wval[HI_W-1:0], mcycle_q[31:0]};
        A_MINSTRET:  minstret_nxt = {minstret_q[COUNTER_W-1:32], wval};
        A_MINSTRETH: minstret_nxt = {wval[HI_W-1:0], minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mstat_mie  <= 1'b0;
      mstat_mpie <= 1'b0;
      mie_q      <= '0;
      mtvec_base <= MTVEC_RESET[31:2];
      mtvec_mode <= MTVEC_RESET[0] & VECTORED_EN;
      mscratch   <= '0;
      mepc_q     <= '0;
      mcause     <= '0;
      mtval      <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_nxt;
      minstret_q <= minstret_nxt;

      if (we && csr_addr == A_MIE)      mie_q <= {wval[11], wval[7], wval[3]};
      if (we && csr_addr == A_MSCRATCH) mscratch <= wval;
      if (we && csr_addr == A_MTVEC) begin
        mtvec_base <= wval[31:2];
        mtvec_mode <= wval[0] & VECTORED_EN;
      end

      if (trap_valid) begin
        mepc_q     <= trap_pc[31:2];
        mcause     <= trap_cause;
        mtval      <= trap_tval;
        mstat_mpie <= mstat_mie;
        mstat_mie  <= 1'b0;
      end else begin
        if (we && csr_addr == A_MEPC)   mepc_q <= wval[31:2];
        if (we && csr_addr == A_MCAUSE) mcause <= wval;
        if (we && csr_addr == A_MTVAL)  mtval  <= wval;
        if (mret) begin
          mstat_mie  <= mstat_mpie;
          mstat_mpie <= 1'b1;
        end else if (we && csr_addr == A_MSTATUS) begin
          mstat_mie  <= wval[3];
          mstat_mpie <= wval[7];
        end
      end
    end
  end

  always_comb begin
    if (mtvec_mode && trap_cause[31])
      trap_vector = {mtvec_base, 2'b00} + {25'h0, trap_cause[4:0], 2'b00};
    else
      trap_vector = {mtvec_base, 2'b00};
  end

  assign mepc_out    = {mepc_q, 2'b00};
  assign irq_pending = mstat_mie && |(mie_q & irq_lines);

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: stimulus pushes expectations from a spec-level model, a negedge monitor pops and compares.
module tb_csr_file;
  localparam logic [31:0] HART  = 32'h0000_0003;
  localparam logic [31:0] MTRST = 32'h0000_0200;
  localparam int          CW    = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_illegal, instr_retire, trap_valid, mret;
  logic [31:0] trap_cause, trap_pc, trap_tval, trap_vector, mepc_out;
  logic        ext_irq, timer_irq, sw_irq, irq_pending;

  csr_file #(.HART_ID(HART), .MTVEC_RESET(MTRST), .VECTORED_EN(1'b1), .COUNTER_W(CW)) dut (
    .clk(clk), .reset(reset), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .instr_retire(instr_retire), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret), .ext_irq(ext_irq),
    .timer_irq(timer_irq), .sw_irq(sw_irq), .trap_vector(trap_vector),
    .mepc_out(mepc_out), .irq_pending(irq_pending));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    logic [31:0] tvec;
    logic        irq;
    logic [31:0] mepc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int passed = 0;

  // Reference state, kept as whole architectural registers.
  bit          m_mie, m_mpie, model_ok;
  logic [31:0] m_miereg, m_mtvec, m_scratch, m_mepc, m_mcause, m_mtval;
  longint unsigned m_cyc, m_ins;
  localparam longint unsigned CMASK = (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);
  logic [2:0] irqs_d = 3'b000;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0; m_miereg = 0; m_mtvec = MTRST; m_scratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
  endfunction

  // Returns {implemented, value}.
  function automatic logic [32:0] model_read(logic [11:0] a, logic [2:0] irqs);
    logic [31:0] v;
    v = 0;
    case (a)
      12'h300: begin v = 32'h1800; v[3] = m_mie; v[7] = m_mpie; end
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_miereg;
      12'h305: v = m_mtvec;
      12'h340: v = m_scratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: begin v[11] = irqs[2]; v[7] = irqs[1]; v[3] = irqs[0]; end
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ins[31:0];
      12'hB82, 12'hC82: v = m_ins[63:32];
      12'hF11, 12'hF12, 12'hF13: v = 0;
      12'hF14: v = HART;
      default: return {1'b0, 32'h0};
    endcase
    return {1'b1, v};
  endfunction

  task automatic step(input bit rst, input bit en, input logic [1:0] op, input logic [11:0] addr,
                      input logic [31:0] wd, input bit ret, input bit tv, input logic [31:0] cause,
                      input logic [31:0] pc, input logic [31:0] tval, input bit mr,
                      input logic [2:0] irqs, input logic [32:0] kr);
    logic [32:0] rd;
    logic [31:0] nv, base;
    bit acc, wrq, ill, dowr;
    longint unsigned cn, inn;
    exp_t e;
    reset = rst; csr_en = en; csr_op = op; csr_addr = addr; csr_wdata = wd;
    instr_retire = ret; trap_valid = tv; trap_cause = cause; trap_pc = pc; trap_tval = tval;
    mret = mr; {ext_irq, timer_irq, sw_irq} = irqs;
    rd   = model_read(addr, irqs);
    acc  = en && (op != 2'b00);
    wrq  = acc && (op == 2'b01 || wd != 0);
    ill  = acc && (!rd[32] || (wrq && addr[11:10] == 2'b11));
    dowr = wrq && !ill;
    nv   = (op == 2'b01) ? wd : (op == 2'b10) ? (rd[31:0] | wd) : (rd[31:0] & ~wd);
    if (model_ok) begin
      base   = m_mtvec & ~32'h3;
      e.rdata = kr[32] ? kr[31:0] : ((acc && !ill) ? rd[31:0] : 32'h0);
      e.ill   = ill;
      e.tvec  = (m_mtvec[0] && cause[31]) ? base + 4 * cause[4:0] : base;
      e.irq   = m_mie && ((irqs[2] && m_miereg[11]) || (irqs[1] && m_miereg[7]) || (irqs[0] && m_miereg[3]));
      e.mepc  = m_mepc;
      q.push_back(e);
    end
    if (rst) begin
      model_reset();
    end else begin
      cn  = (m_cyc + 1) & CMASK;
      inn = ret ? ((m_ins + 1) & CMASK) : m_ins;
      if (dowr) begin
        case (addr)
          12'h304: m_miereg = nv & 32'h0000_0888;
          12'h305: m_mtvec = {nv[31:2], 1'b0, nv[0]};
          12'h340: m_scratch = nv;
          12'h341: if (!tv) m_mepc = nv & ~32'h3;
          12'h342: if (!tv) m_mcause = nv;
          12'h343: if (!tv) m_mtval = nv;
          12'h300: if (!tv && !mr) begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'hB00: cn  = {m_cyc[63:32], nv} & CMASK;
          12'hB80: cn  = {nv, m_cyc[31:0]} & CMASK;
          12'hB02: inn = {m_ins[63:32], nv} & CMASK;
          12'hB82: inn = {nv, m_ins[31:0]} & CMASK;
          default: ;
        endcase
      end
      if (tv) begin
        m_mepc = pc & ~32'h3; m_mcause = cause; m_mtval = tval; m_mpie = m_mie; m_mie = 0;
      end else if (mr) begin
        m_mie = m_mpie; m_mpie = 1;
      end
      m_cyc = cn; m_ins = inn;
    end
    @(posedge clk); #1;
  endtask

  task automatic acc_op(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input logic [32:0] kr);
    step(0, 1, op, a, wd, 0, 0, 0, 0, 0, 0, irqs_d, kr);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] k);
    acc_op(2'b10, a, 0, {1'b1, k});
  endtask

  // Monitor: one expectation per cycle, compared half a period after the inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rdata", csr_rdata, e.rdata);
        chk("illegal", {31'h0, csr_illegal}, {31'h0, e.ill});
        chk("trap_vector", trap_vector, e.tvec);
        chk("irq_pending", {31'h0, irq_pending}, {31'h0, e.irq});
        chk("mepc_out", mepc_out, e.mepc);
      end
    end
  end

  logic [11:0] alist[25] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                             12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                             12'hC80, 12'hC02, 12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14,
                             12'h7C0, 12'h345, 12'hB03, 12'hF15};

  initial begin
    reset = 1; csr_en = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0; instr_retire = 0;
    trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0; mret = 0;
    ext_irq = 0; timer_irq = 0; sw_irq = 0;
    @(posedge clk); #1;
    model_reset(); model_ok = 1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, {1'b1, 32'h0});
    rd(12'hB00, 32'h0);
    rd(12'hB00, 32'h1);
    rd(12'h300, 32'h1800);
    rd(12'h304, 32'h0);
    rd(12'h341, 32'h0);
    rd(12'hF14, HART);
    rd(12'h301, 32'h4000_0100);
    acc_op(2'b01, 12'h340, 32'hDEAD_BEEF, {1'b1, 32'h0});
    acc_op(2'b10, 12'h340, 32'h0000_00FF, {1'b1, 32'hDEAD_BEEF});
    acc_op(2'b11, 12'h340, 32'hFF00_0000, {1'b1, 32'hDEAD_BEFF});
    rd(12'h340, 32'h00AD_BEFF);
    acc_op(2'b01, 12'hC00, 32'h1234, {1'b1, 32'h0});
    acc_op(2'b01, 12'h7C0, 32'h1234, {1'b1, 32'h0});
    acc_op(2'b10, 12'hC00, 32'h0, 0);
    // interrupt, trap entry and MRET
    acc_op(2'b01, 12'h300, 32'h8, 0);
    acc_op(2'b01, 12'h304, 32'h80, {1'b1, 32'h0});
    irqs_d = 3'b010;
    acc_op(2'b01, 12'h305, 32'h1001, {1'b1, MTRST});
    rd(12'h300, 32'h1808);
    step(0, 0, 0, 0, 0, 0, 1, 32'h8000_0007, 32'h104, 32'h55, 0, irqs_d, {1'b1, 32'h0});
    rd(12'h341, 32'h104);
    rd(12'h300, 32'h1880);
    step(0, 0, 0, 0, 0, 0, 0, 32'h8000_0003, 0, 0, 1, irqs_d, {1'b1, 32'h0});
    rd(12'h300, 32'h1888);
    irqs_d = 3'b000;
    // counter carry and write-over-increment
    acc_op(2'b01, 12'hB80, 32'h0, 0);
    acc_op(2'b01, 12'hB00, 32'hFFFF_FFFF, 0);
    rd(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB80, 32'h1);
    // trap beats mret beats mstatus write in one cycle
    acc_op(2'b01, 12'h300, 32'h8, 0);
    step(0, 1, 2'b01, 12'h300, 32'h8, 0, 1, 32'h2, 32'h203, 32'h0, 1, 0, 0);
    rd(12'h300, 32'h1880);
    rd(12'h341, 32'h200);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] wd;
      logic [31:0] cause;
      case ($urandom_range(0, 3))
        0: wd = 0;
        1: wd = $urandom_range(0, 31);
        default: wd = $urandom;
      endcase
      cause = {$urandom_range(0, 1) == 1, 26'h0, 5'($urandom_range(0, 31))};
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           alist[$urandom_range(0, 24)], wd, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, cause, $urandom, $urandom,
           $urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)), 0);
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/csr_file.md
# csr_file

Parametrised machine-mode control and status register file for the RISC-V soft core. It decodes the implemented M-mode CSRs, executes CSRRW/CSRRS/CSRRC read-modify-write semantics, and flags illegal accesses. It also maintains 64-bit cycle/instret counters, performs trap-entry and MRET state updates, and produces the trap vector and interrupt-pending signal consumed by the core's execute/writeback stage.

## Interface

- HART_ID, 0: value returned by mhartid (0xF14)
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec
- VECTORED_EN, 1: 1 = mtvec MODE=1 (vectored) is writable; 0 = MODE forced to 0
- COUNTER_W, 64: implemented width of mcycle/minstret (33..64); upper unimplemented bits read 0

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- csr_en  in  1  CSR instruction valid this cycle
- csr_op  in  2  01 RW, 10 RS, 11 RC; 00 ignored (no access)
- csr_addr  in  12  CSR address
- csr_wdata  in  32  rs1 value or zero-extended uimm
- csr_rdata  out  32  old CSR value, combinational
- csr_illegal  out  1  combinational illegal-access flag
- instr_retire  in  1  one instruction retired this cycle
- trap_valid  in  1  take trap this cycle
- trap_cause  in  32  mcause value (bit31 = interrupt)
- trap_pc  in  32  PC of trapping instruction
- trap_tval  in  32  mtval value
- mret  in  1  MRET executed this cycle
- ext_irq, timer_irq, sw_irq  in  1 each  interrupt lines (level)
- trap_vector  out  32  trap target PC, combinational
- mepc_out  out  32  current mepc (MRET target)
- irq_pending  out  1  enabled interrupt pending and mstatus.MIE=1

## Operation

- Implemented: mstatus 0x300 (MIE b3, MPIE b7, MPP b12:11 read 2'b11, others 0), misa 0x301 RO-as-WARL (reads 32'h4000_0100, writes ignored), mie 0x304 (b11/b7/b3 writable), mtvec 0x305, mscratch 0x340, mepc 0x341 (b1:0 read 0), mcause 0x342, mtval 0x343, mip 0x344 (read-only: b11=ext_irq, b7=timer_irq, b3=sw_irq), mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82 (RO shadows), mvendorid/marchid/mimpid 0xF11-0xF13 (read 0), mhartid 0xF14.
- Write value: RW = wdata; RS = old | wdata; RC = old & ~wdata.
- RS/RC with csr_wdata==0 are read-only accesses (no write, no side effect).
- csr_illegal=1 when csr_en and csr_op!=00 and (address unimplemented, or a write occurs to addr[11:10]==2'b11). Illegal accesses change no state; csr_rdata=0.
- csr_rdata = 0 whenever csr_en=0 or csr_op=00.
- mtvec: MODE b1:0; b1 always 0; b0 writable only if VECTORED_EN. trap_vector = base if MODE=0 or trap_cause[31]=0, else base + 4*trap_cause[4:0].
- Trap entry (trap_valid): mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0.
- MRET: MIE<=MPIE, MPIE<=1.
- Priority within a cycle: trap_valid > mret > CSR write. Lower-priority updates to the same registers are dropped; CSR writes to unrelated registers still commit.
- Counters: mcycle +1 every cycle, minstret +1 when instr_retire. A CSR write to either half of a counter wins over its increment that cycle. The other half holds (no carry from the suppressed increment). Counters wrap at 2^COUNTER_W to 0.
- irq_pending = MIE & |(mip & mie).

## Timing

- Reads combinational from current state. All updates at posedge clk. A read in cycle N returns the value written in N-1.
- Trap/MRET effects visible on csr_rdata, trap_vector and irq_pending the cycle after assertion.
- Reset (any cycle, including mid-trap): mstatus MIE=MPIE=0, mie=0, mtvec=MTVEC_RESET, mscratch=mepc=mcause=mtval=0, counters=0. Outputs after reset: csr_rdata=0 (csr_en low), csr_illegal=0, irq_pending=0, mepc_out=0, trap_vector=MTVEC_RESET&~3.
- mcycle reads 0 in the first cycle after reset release and 1 in the next.

## Test plan

- Reset, then read 0x300/0x304/0x341 -> 0. Read 0xF14 -> HART_ID. Read 0x301 -> 32'h4000_0100.
- RW 0x340 = 32'hDEAD_BEEF -> csr_rdata is the old 0. Then RS 32'h0000_00FF -> rdata DEAD_BEEF. Then RC 32'hFF00_0000 -> next read 32'h00AD_BEFF.
- RW to 0xC00, or to unimplemented 0x7C0 -> csr_illegal=1, no state change. RS 0xC00 with wdata 0 -> legal, returns cycle.
- mstatus MIE=1, mie b7=1, timer_irq=1 -> irq_pending=1. Then trap_valid with cause 32'h8000_0007, pc 32'h104, mtvec=32'h1001 -> trap_vector 32'h101C, mepc 32'h104, MIE=0, MPIE=1. Then MRET -> MIE=1.
- Write mcycle=32'hFFFF_FFFF, mcycleh=0 -> two cycles later mcycleh=1. Write on the same cycle as an increment -> written value holds.
- trap_valid and mret and a CSR write to mstatus in one cycle -> trap-entry result only.
